mem_arbiter: RTL and testbench

Shares the single-ported, multi-cycle main memory between the instruction-fetch miss path (I-port) and the data-memory miss/write path (D-port). It holds one transaction at a time and sequences it through an IDLE/I_BUSY/D_BUSY state machine. It returns read data or a write-done ack to the requester that owns the grant. It stalls the other requester until its own transaction completes. The block sits between the I/D cache controllers and the memory model, below the Fetch stage.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_counter.sv | 27 ++
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D main-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_t;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  localparam int WR_CYCLES_DEFAULT = 4;

  // Width needed to hold a count of n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_arb_counter.sv
// Loadable down-counter with a zero flag; sets how long a write occupies memory.
module mem_arb_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Single-transaction arbiter sharing main memory between the I-fetch and D-miss paths.
// ARB_RR_EN selects round-robin tie-breaking; otherwise the D-port has fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WR_CYCLES = WR_CYCLES_DEFAULT,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_stall,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid
);

  localparam int            CW      = cnt_width(WR_CYCLES);
  localparam logic [CW-1:0] WR_LOAD = CW'(WR_CYCLES - 1);

  arb_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              wr_reg;
  logic              en_reg;
  logic              i_ack_reg;
  logic              d_ack_reg;

  logic i_elig, d_elig;
  logic pick_i, pick_d, grant;
  logic rd_done, wr_done, done;
  logic cnt_load, cnt_dec, cnt_zero;

  // The port being acked still shows req this cycle; it must not be regranted.
  assign i_elig = i_req && !i_ack_reg;
  assign d_elig = d_req && !d_ack_reg;

`ifdef ARB_RR_EN
  logic ptr_reg;

  assign pick_d = d_elig && (!i_elig || (ptr_reg == REQ_D));

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= REQ_D;
    end else if (done) begin
      ptr_reg <= ~ptr_reg;
    end
  end
`else
  assign pick_d = d_elig;
`endif

  assign pick_i = i_elig && !pick_d;
  assign grant  = (state_reg == IDLE) && (pick_i || pick_d);
  assign done   = rd_done || wr_done;

  always_comb begin
    state_next = state_reg;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    rd_done    = 1'b0;
    wr_done    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_d) begin
          state_next = D_BUSY;
          cnt_load   = d_wr;
        end else if (pick_i) begin
          state_next = I_BUSY;
        end
      end
      I_BUSY: begin
        if (mem_valid) begin
          rd_done    = 1'b1;
          state_next = IDLE;
        end
      end
      D_BUSY: begin
        // Writes complete on occupancy alone; mem_valid is meaningless there.
        if (wr_reg) begin
          if (cnt_zero) begin
            wr_done    = 1'b1;
            state_next = IDLE;
          end else begin
            cnt_dec = 1'b1;
          end
        end else if (mem_valid) begin
          rd_done    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      wr_reg    <= 1'b0;
      en_reg    <= 1'b0;
      i_ack_reg <= 1'b0;
      d_ack_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      i_ack_reg <= (state_reg == I_BUSY) && done;
      d_ack_reg <= (state_reg == D_BUSY) && done;
      if (rd_done) begin
        rdata_reg <= mem_rdata;
      end
      if (grant) begin
        en_reg    <= 1'b1;
        wr_reg    <= pick_d && d_wr;
        addr_reg  <= pick_d ? d_addr : i_addr;
        wdata_reg <= pick_d ? d_wdata : '0;
      end else if (done) begin
        en_reg <= 1'b0;
        wr_reg <= 1'b0;
      end
    end
  end

  mem_arb_counter #(
    .W(CW)
  ) u_wr_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .load_value (WR_LOAD),
    .dec        (cnt_dec),
    .zero       (cnt_zero)
  );

  assign i_ack     = i_ack_reg;
  assign d_ack     = d_ack_reg;
  assign i_stall   = i_req && !i_ack_reg;
  assign d_stall   = d_req && !d_ack_reg;
  assign rdata     = rdata_reg;
  assign mem_en    = en_reg;
  assign mem_wr    = wr_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed timing cases, then randomized I/D traffic.
module tb_mem_arbiter;

  localparam int WR = 4;

  typedef struct packed {
    logic        wr;
    logic [15:0] data;
  } exp_t;

  logic        clk, rst;
  logic        i_req, i_ack, i_stall;
  logic [15:0] i_addr;
  logic        d_req, d_wr, d_ack, d_stall;
  logic [15:0] d_addr, d_wdata;
  logic [15:0] rdata;
  logic        mem_en, mem_wr, mem_valid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;
  exp_t iq[$];
  exp_t dq[$];
  logic [15:0] ref_mem  [logic [15:0]];
  logic [15:0] phys_mem [logic [15:0]];
  logic [15:0] last_rdata = '0;
  bit   rst_d    = 1'b1;
  bit   ptr_m    = 1'b1;
  bit   spur_en  = 1'b0;
  bit   spur_all = 1'b0;
  bit   rand_lat = 1'b0;

  mem_arbiter #(
    .WR_CYCLES (WR),
    .ADDR_W    (16),
    .DATA_W    (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .i_stall   (i_stall),
    .d_req     (d_req),
    .d_wr      (d_wr),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_stall   (d_stall),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a ^ 16'h3C5A ^ {a[7:0], a[15:8]};
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  function automatic logic [15:0] phys_rd(input logic [15:0] a);
    if (phys_mem.exists(a)) return phys_mem[a];
    return init_val(a);
  endfunction

  // Tie-break winner expected from the arbitration policy alone.
  function automatic bit exp_d_first();
`ifdef ARB_RR_EN
    return ptr_m;
`else
    return 1'b1;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Memory model: read data after a per-transaction latency, writes stored, optional spurious valids.
  initial begin
    int rd_cnt;
    int lat;
    rd_cnt    = 0;
    lat       = 4;
    mem_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_valid = 1'b0;
      if (mem_en && mem_wr) phys_mem[mem_addr] = mem_wdata;
      if (mem_en && !mem_wr) begin
        rd_cnt++;
        if (rd_cnt == 1) lat = rand_lat ? int'($urandom_range(1, 5)) : 4;
        if (rd_cnt == lat) begin
          mem_valid = 1'b1;
          mem_rdata = phys_rd(mem_addr);
        end
      end else begin
        rd_cnt = 0;
        if (spur_all || (spur_en && $urandom_range(0, 3) == 0)) begin
          mem_valid = 1'b1;
          mem_rdata = 16'($urandom);
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every ack and checks stalls and rdata stability.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        rst_d = 1'b1;
        ptr_m = 1'b1;
      end else begin
        if (rst_d) begin
          last_rdata = '0;
          rst_d      = 1'b0;
        end
        check("i_stall", i_stall, i_req && !i_ack);
        check("d_stall", d_stall, d_req && !d_ack);
        check("dual_ack", i_ack & d_ack, 0);
        if (i_ack) begin
          check("i_ack_expected", iq.size() > 0, 1);
          if (iq.size() > 0) begin
            e = iq.pop_front();
            check("i_rdata", rdata, e.data);
            last_rdata = e.data;
          end
          ptr_m = ~ptr_m;
        end else if (d_ack) begin
          check("d_ack_expected", dq.size() > 0, 1);
          if (dq.size() > 0) begin
            e = dq.pop_front();
            if (e.wr) begin
              check("d_wr_rdata_hold", rdata, last_rdata);
            end else begin
              check("d_rdata", rdata, e.data);
              last_rdata = e.data;
            end
          end
          ptr_m = ~ptr_m;
        end else begin
          check("rdata_hold", rdata, last_rdata);
        end
      end
    end
  end

  task automatic i_txn(input logic [15:0] a, output int ack_at);
    int   n;
    exp_t e;
    i_addr = a;
    i_req  = 1'b1;
    e.wr   = 1'b0;
    e.data = ref_rd(a);
    iq.push_back(e);
    n      = 0;
    ack_at = -1;
    do begin
      @(negedge clk);
      n++;
    end while (!i_ack && n < 300);
    check("i_ack_timeout", i_ack, 1);
    if (i_ack) ack_at = cyc;
    @(posedge clk);
    #1;
    i_req = 1'b0;
  endtask

  task automatic d_txn(input logic w, input logic [15:0] a, input logic [15:0] wd, output int ack_at);
    int   n;
    exp_t e;
    d_wr    = w;
    d_addr  = a;
    d_wdata = wd;
    d_req   = 1'b1;
    e.wr    = w;
    if (w) begin
      e.data     = wd;
      ref_mem[a] = wd;
    end else begin
      e.data = ref_rd(a);
    end
    dq.push_back(e);
    n      = 0;
    ack_at = -1;
    do begin
      @(negedge clk);
      n++;
    end while (!d_ack && n < 300);
    check("d_ack_timeout", d_ack, 1);
    if (d_ack) ack_at = cyc;
    @(posedge clk);
    #1;
    d_req = 1'b0;
  endtask

  initial begin
    int  t0, ti, td;
    bit  edf;
    rst     = 1'b1;
    i_req   = 1'b0;
    i_addr  = '0;
    d_req   = 1'b0;
    d_wr    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_mem_en", mem_en, 0);
    check("reset_mem_wr", mem_wr, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_mem_wdata", mem_wdata, 0);
    check("reset_acks", {i_ack, d_ack}, 0);
    check("reset_rdata", rdata, 0);
    @(posedge clk);
    #1;

    // Lone I read with 4-cycle memory.
    phys_mem[16'h0010] = 16'hA5A5;
    ref_mem[16'h0010]  = 16'hA5A5;
    t0 = cyc;
    i_txn(16'h0010, ti);
    check("lone_i_ack_cycle", ti, t0 + 5);

    // Simultaneous I and D read.
    edf = exp_d_first();
    t0  = cyc;
    fork
      i_txn(16'h0100, ti);
      d_txn(1'b0, 16'h0200, 16'h0000, td);
    join
    check("tie_first_ack_cycle", edf ? td : ti, t0 + 5);
    check("tie_second_ack_cycle", edf ? ti : td, t0 + 10);

    // Consecutive ties: service order must follow the policy each round.
    for (int r = 0; r < 2; r++) begin
      edf = exp_d_first();
      fork
        i_txn(16'h0040 + 16'(r), ti);
        d_txn(1'b0, 16'h0050 + 16'(r), 16'h0000, td);
      join
      check("tie_round_d_first", td < ti, edf);
    end

    // D write: mem_wr and wdata held for WR cycles, ack right after.
    t0 = cyc;
    fork
      d_txn(1'b1, 16'h0300, 16'hBEEF, td);
      begin
        for (int k = 0; k <= WR + 1; k++) begin
          @(negedge clk);
          check("wr_mem_wr", mem_wr, (k >= 1 && k <= WR));
          if (k >= 1 && k <= WR) check("wr_mem_wdata", {mem_en, mem_addr, mem_wdata}, {1'b1, 16'h0300, 16'hBEEF});
        end
      end
    join
    check("wr_ack_cycle", td, t0 + WR + 1);

    // Reset in cycle 2 of an I read: aborted, then re-served.
    t0 = cyc;
    fork
      i_txn(16'h0020, ti);
      begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_mem_en", mem_en, 0);
        check("abort_no_i_ack", i_ack, 0);
      end
    join
    check("abort_reserve_ack_cycle", ti, t0 + 8);

    // Spurious mem_valid while idle and during a write.
    spur_all = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    t0 = cyc;
    d_txn(1'b1, 16'h0310, 16'h1234, td);
    check("spur_wr_ack_cycle", td, t0 + WR + 1);
    spur_all = 1'b0;
    t0 = cyc;
    d_txn(1'b0, 16'h0310, 16'h0000, td);
    i_txn(16'h0010, ti);

    // Randomized concurrent traffic with variable latency and spurious valids.
    spur_en  = 1'b1;
    rand_lat = 1'b1;
    fork
      for (int n = 0; n < 40; n++) begin
        automatic int          g = $urandom_range(0, 3);
        automatic logic [15:0] a = {8'h00, 8'($urandom)};
        automatic int          t;
        repeat (g) begin
          @(posedge clk);
          #1;
        end
        i_txn(a, t);
      end
      for (int n = 0; n < 40; n++) begin
        automatic int          g = $urandom_range(0, 3);
        automatic logic        w = 1'($urandom_range(0, 1));
        automatic logic [15:0] a = w ? (16'h0300 | 16'($urandom_range(0, 255)))
                                     : 16'($urandom_range(0, 16'h03FF));
        automatic logic [15:0] wd = 16'($urandom);
        automatic int          t;
        repeat (g) begin
          @(posedge clk);
          #1;
        end
        d_txn(w, a, wd, t);
      end
    join
    spur_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("i_queue_drained", iq.size(), 0);
    check("d_queue_drained", dq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
